rr_enqueue_arbiter: RTL



---
 rtl/rr_enqueue_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rr_enqueue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_enqueue_arbiter
// Brief    : Round-robin, burst-bounded arbiter sharing one FIFO enqueue port.
// Revision : 1.0 - initial release
// ============================================================================
module rr_enqueue_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int c_IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic                     fifo_is_full,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     enqueue_request,
    output logic [WIDTH-1:0]         data_out,
    output logic [c_IDW-1:0]         owner,
    output logic                     locked
);

    localparam int c_CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_BURST = 1'b1;

    logic [0:0]       r_state;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_owner;
    logic [c_CW-1:0]  r_count;
    logic             r_locked;

    logic [0:0]       w_state_nxt;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [c_IDW-1:0] w_owner_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic             w_fire;
    logic [c_IDW-1:0] w_sel;
    logic             w_found;
    logic [c_IDW-1:0] w_pick;

    // Explicit wrap keeps rotation correct when NUM_REQ is not a power of two.
    function automatic logic [c_IDW-1:0] f_next(input logic [c_IDW-1:0] i);
        return (i == c_IDW'(NUM_REQ - 1)) ? '0 : i + c_IDW'(1);
    endfunction

    // Cyclic priority search: indices at or above the pointer first, then the rest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (c_IDW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = c_IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                w_pick  = c_IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_count  <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_count  <= w_count_nxt;
            r_locked <= (w_state_nxt == c_S_BURST);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_fire      = 1'b0;
        w_sel       = r_owner;
        case (r_state)
            c_S_IDLE: begin
                if (!fifo_is_full && w_found) begin
                    w_fire      = 1'b1;
                    w_sel       = w_pick;
                    w_owner_nxt = w_pick;
                    w_count_nxt = c_CW'(1);
                    if (MAX_BURST == 1) begin
                        w_ptr_nxt = f_next(w_pick);
                    end else begin
                        w_state_nxt = c_S_BURST;
                    end
                end
            end
            c_S_BURST: begin
                // A full FIFO freezes the burst without spending its budget.
                if (!fifo_is_full) begin
                    if (req[r_owner]) begin
                        w_fire      = 1'b1;
                        w_count_nxt = r_count + c_CW'(1);
                        if (w_count_nxt == c_CW'(MAX_BURST)) begin
                            w_state_nxt = c_S_IDLE;
                            w_ptr_nxt   = f_next(r_owner);
                        end
                    end else begin
                        w_state_nxt = c_S_IDLE;
                        w_ptr_nxt   = f_next(r_owner);
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        grant    = '0;
        data_out = '0;
        if (!reset && w_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_sel == c_IDW'(i)) begin
                    grant[i] = 1'b1;
                    data_out = data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign enqueue_request = |grant;
    assign owner           = r_owner;
    assign locked          = r_locked;

endmodule
`default_nettype wire
